// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/loader memory port arbiter; define DM_ARB_RR_EN for round-robin on contested cycles
module dm_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        C_REQ,
  input  logic        C_WE,
  input  logic [31:0] C_ADR,
  input  logic [31:0] C_WDATA,
  input  logic        L_REQ,
  input  logic        L_WE,
  input  logic [31:0] L_ADR,
  input  logic [31:0] L_WDATA,
  input  logic        L_LOCK,
  output logic        C_GNT,
  output logic        C_RVALID,
  output logic [31:0] C_RDATA,
  output logic        C_ERR,
  output logic        CPU_STALL,
  output logic        L_GNT,
  output logic        L_RVALID,
  output logic [31:0] L_RDATA,
  output logic        L_ERR,
  output logic        M_WE,
  output logic [31:0] M_ADR,
  output logic [31:0] M_WDATA,
  input  logic [31:0] M_RDATA
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } own_t;

  own_t        state;
  own_t        state_nxt;
  logic        c_win;
  logic        l_win;
  logic        cpu_first;
  logic        misaligned;
  logic        win_we;
  logic [31:0] win_adr;
  logic [31:0] win_wdata;
  logic        c_rd_pend;
  logic        l_rd_pend;
  logic        c_err_pend;
  logic        l_err_pend;

`ifdef DM_ARB_RR_EN
  logic prefer_cpu;

  // Remember the loser of the last contested cycle so it wins the next one
  always_ff @(posedge CLK) begin
    if (RST) begin
      prefer_cpu <= 1'b1;
    end else if (C_REQ && L_REQ) begin
      prefer_cpu <= l_win;
    end
  end

  assign cpu_first = prefer_cpu;
`else
  assign cpu_first = 1'b1;
`endif

  // Ownership state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= OWN_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next ownership is simply whoever won this cycle
  always_comb begin
    state_nxt = OWN_NONE;
    if (l_win) begin
      state_nxt = OWN_LDR;
    end else if (c_win) begin
      state_nxt = OWN_CPU;
    end
  end

  // Grant decision and memory-side mux; a locked loader keeps the port
  always_comb begin
    c_win     = 1'b0;
    l_win     = 1'b0;
    win_we    = 1'b0;
    win_adr   = 32'd0;
    win_wdata = 32'd0;
    if (!RST) begin
      if (state == OWN_LDR && L_LOCK && L_REQ) begin
        l_win = 1'b1;
      end else if (C_REQ && L_REQ) begin
        c_win = cpu_first;
        l_win = !cpu_first;
      end else if (C_REQ) begin
        c_win = 1'b1;
      end else if (L_REQ) begin
        l_win = 1'b1;
      end
    end
    if (c_win) begin
      win_we    = C_WE;
      win_adr   = C_ADR;
      win_wdata = C_WDATA;
    end else if (l_win) begin
      win_we    = L_WE;
      win_adr   = L_ADR;
      win_wdata = L_WDATA;
    end
    misaligned = (c_win || l_win) && (win_adr[1:0] != 2'b00);
    M_WE       = win_we && !misaligned;
    M_ADR      = win_adr;
    M_WDATA    = win_wdata;
    C_GNT      = c_win;
    L_GNT      = l_win;
    CPU_STALL  = C_REQ && !c_win;
  end

  // Track granted reads and misaligned accesses for the following cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      c_rd_pend  <= 1'b0;
      l_rd_pend  <= 1'b0;
      c_err_pend <= 1'b0;
      l_err_pend <= 1'b0;
    end else begin
      c_rd_pend  <= c_win && !C_WE && !misaligned;
      l_rd_pend  <= l_win && !L_WE && !misaligned;
      c_err_pend <= c_win && misaligned;
      l_err_pend <= l_win && misaligned;
    end
  end

  // Responses; a reset cycle swallows whatever was issued just before it
  always_comb begin
    C_RVALID = c_rd_pend && !RST;
    L_RVALID = l_rd_pend && !RST;
    C_ERR    = c_err_pend && !RST;
    L_ERR    = l_err_pend && !RST;
    C_RDATA  = C_RVALID ? M_RDATA : 32'd0;
    L_RDATA  = L_RVALID ? M_RDATA : 32'd0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter
module tb_dm_arbiter;

  logic        CLK;
  logic        RST;
  logic        C_REQ;
  logic        C_WE;
  logic [31:0] C_ADR;
  logic [31:0] C_WDATA;
  logic        L_REQ;
  logic        L_WE;
  logic [31:0] L_ADR;
  logic [31:0] L_WDATA;
  logic        L_LOCK;
  logic        C_GNT;
  logic        C_RVALID;
  logic [31:0] C_RDATA;
  logic        C_ERR;
  logic        CPU_STALL;
  logic        L_GNT;
  logic        L_RVALID;
  logic [31:0] L_RDATA;
  logic        L_ERR;
  logic        M_WE;
  logic [31:0] M_ADR;
  logic [31:0] M_WDATA;
  logic [31:0] M_RDATA;

  typedef struct {
    int          cyc;
    bit          cpu;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  int          compared;
  int          mismatched;
  int          cyc;
  logic [31:0] rd_next;

  dm_arbiter dut (
    .CLK(CLK), .RST(RST),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_ADR(C_ADR), .C_WDATA(C_WDATA),
    .L_REQ(L_REQ), .L_WE(L_WE), .L_ADR(L_ADR), .L_WDATA(L_WDATA), .L_LOCK(L_LOCK),
    .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA), .C_ERR(C_ERR),
    .CPU_STALL(CPU_STALL),
    .L_GNT(L_GNT), .L_RVALID(L_RVALID), .L_RDATA(L_RDATA), .L_ERR(L_ERR),
    .M_WE(M_WE), .M_ADR(M_ADR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at posedge+5, then advance
  task automatic step(input bit rst, input bit creq, input bit cwe, input logic [31:0] cadr,
                      input bit lreq, input bit lwe, input logic [31:0] ladr, input bit llock,
                      input bit ecg, input bit elg);
    resp_t       e;
    bit          have;
    bit          ew;
    logic [31:0] ea;
    logic [31:0] ed;
    bit          mis;
    RST     = rst;
    C_REQ   = creq;
    C_WE    = cwe;
    C_ADR   = cadr;
    C_WDATA = cadr ^ 32'hC0DE_0000;
    L_REQ   = lreq;
    L_WE    = lwe;
    L_ADR   = ladr;
    L_WDATA = ladr ^ 32'h1D00_0000;
    L_LOCK  = llock;
    M_RDATA = rd_next;
    #4;
    ew = 1'b0; ea = 32'd0; ed = 32'd0;
    if (ecg) begin ew = cwe; ea = cadr; ed = C_WDATA; end
    else if (elg) begin ew = lwe; ea = ladr; ed = L_WDATA; end
    mis = (ecg || elg) && (ea[1:0] != 2'b00);
    chk("c_gnt", 32'(C_GNT), 32'(ecg));
    chk("l_gnt", 32'(L_GNT), 32'(elg));
    chk("cpu_stall", 32'(CPU_STALL), 32'(creq && !ecg));
    chk("m_we", 32'(M_WE), 32'(ew && !mis));
    chk("m_adr", M_ADR, ea);
    chk("m_wdata", M_WDATA, ed);
    have = 1'b0;
    e = '{cyc: 0, cpu: 1'b0, err: 1'b0, data: 32'd0};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      have = !rst;
    end
    chk("c_rvalid", 32'(C_RVALID), 32'(have && e.cpu && !e.err));
    chk("c_rdata", C_RDATA, (have && e.cpu && !e.err) ? e.data : 32'd0);
    chk("c_err", 32'(C_ERR), 32'(have && e.cpu && e.err));
    chk("l_rvalid", 32'(L_RVALID), 32'(have && !e.cpu && !e.err));
    chk("l_rdata", L_RDATA, (have && !e.cpu && !e.err) ? e.data : 32'd0);
    chk("l_err", 32'(L_ERR), 32'(have && !e.cpu && e.err));
    rd_next = 32'h5A5A_1234;
    if (rst) begin
      sb.delete();
    end else if (ecg || elg) begin
      if (mis) begin
        sb.push_back('{cyc: cyc + 1, cpu: ecg, err: 1'b1, data: 32'd0});
      end else if (!ew) begin
        sb.push_back('{cyc: cyc + 1, cpu: ecg, err: 1'b0, data: mem_fn(ea)});
        rd_next = mem_fn(ea);
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rd_next    = 32'd0;
    RST = 1'b1; C_REQ = 1'b0; C_WE = 1'b0; C_ADR = 32'd0; C_WDATA = 32'd0;
    L_REQ = 1'b0; L_WE = 1'b0; L_ADR = 32'd0; L_WDATA = 32'd0; L_LOCK = 1'b0;
    M_RDATA = 32'd0;
    @(posedge CLK);
    #1;
    // reset: requests present but no grant, no responses
    step(1, 1, 0, 32'h10, 1, 0, 32'h100, 0, 0, 0);
    step(1, 0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 0);
    chk("state_after_reset", 32'(dut.state), 32'd0);
    // single CPU read of 0x10
    step(0, 1, 0, 32'h10, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0,  0, 0, 32'h0, 0, 0, 0);
    // three contested cycles, then loader alone
`ifdef DM_ARB_RR_EN
    step(0, 1, 0, 32'h20, 1, 0, 32'h100, 0, 1, 0);
    step(0, 1, 0, 32'h24, 1, 0, 32'h100, 0, 0, 1);
    step(0, 1, 0, 32'h24, 1, 0, 32'h104, 0, 1, 0);
`else
    step(0, 1, 0, 32'h20, 1, 0, 32'h100, 0, 1, 0);
    step(0, 1, 0, 32'h24, 1, 0, 32'h100, 0, 1, 0);
    step(0, 1, 0, 32'h28, 1, 0, 32'h100, 0, 1, 0);
`endif
    step(0, 0, 0, 32'h0, 1, 0, 32'h104, 0, 0, 1);
    // loader write, then locked loader reads against a waiting CPU
    step(0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 0, 1);
    step(0, 1, 0, 32'h300, 1, 0, 32'h204, 1, 0, 1);
    step(0, 1, 0, 32'h300, 1, 0, 32'h208, 1, 0, 1);
    step(0, 1, 0, 32'h300, 1, 0, 32'h20C, 1, 0, 1);
    step(0, 1, 0, 32'h300, 1, 0, 32'h210, 1, 0, 1);
    step(0, 1, 0, 32'h300, 0, 0, 32'h0,   0, 1, 0);
    // misaligned CPU store and loader read, aligned CPU store
    step(0, 1, 1, 32'h13, 0, 0, 32'h0,   0, 1, 0);
    step(0, 0, 0, 32'h0,  1, 0, 32'h202, 0, 0, 1);
    step(0, 1, 1, 32'h40, 0, 0, 32'h0,   0, 1, 0);
    step(0, 0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 0);
    // back-to-back reads, reset right behind the second one
    step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 0, 32'h4, 0, 0, 32'h0, 0, 1, 0);
    step(1, 1, 0, 32'h8, 0, 0, 32'h0, 0, 0, 0);
    chk("state_after_rst", 32'(dut.state), 32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have: RST  in  1  synchronous active-high reset.
REQ-003 SHALL have: C_REQ  in  1  CPU memory-stage request; C_WE  in  1  CPU store; C_ADR  in  32  CPU byte address; C_WDATA  in  32  CPU store data.
REQ-004 SHALL have: L_REQ  in  1  loader/debug request; L_WE  in  1  loader store; L_ADR  in  32  loader address; L_WDATA  in  32  loader store data; L_LOCK  in  1  loader keeps ownership.
REQ-005 SHALL have: C_GNT  out  1; C_RVALID  out  1; C_RDATA  out  32; C_ERR  out  1; CPU_STALL  out  1; L_GNT  out  1; L_RVALID  out  1; L_RDATA  out  32; L_ERR  out  1.
REQ-006 SHALL have memory side: M_WE  out  1; M_ADR  out  32; M_WDATA  out  32; M_RDATA  in  32, valid one cycle after the address.

Function
REQ-007 SHALL grant at most one requester per cycle; a grant is combinational in the request cycle and the access is issued to memory that cycle.
REQ-008 SHALL hold requests valid, with stable WE/ADR/WDATA, until granted; dropping an ungranted request is permitted and SHALL have no effect.
REQ-009 SHALL maintain ownership FSM OWN_NONE, OWN_CPU, OWN_LDR, recording the winner of the last granted cycle; no grant -> OWN_NONE.
REQ-010 SHALL use fixed priority with macro absent: CPU wins when both request, except in REQ-011.
REQ-011 SHALL, when state is OWN_LDR and L_LOCK=1 and L_REQ=1, grant loader regardless of C_REQ.
REQ-012 SHALL drive M_WE=GNT&WE of the winner, and M_ADR/M_WDATA from the winner; with no grant, M_WE=0 and M_ADR/M_WDATA=0.
REQ-013 SHALL, for a granted read, assert winner's RVALID exactly one cycle later for one cycle, with RDATA=M_RDATA; no RVALID for stores.
REQ-014 SHALL keep RDATA at 0 when RVALID=0.
REQ-015 SHALL treat ADR[1:0]!=0 as misaligned: GNT still asserted, M_WE forced 0, no RVALID; the requester's ERR pulses one cycle later.
REQ-016 SHALL drive CPU_STALL=C_REQ&~C_GNT combinationally.
REQ-017 SHALL accept a new grant in the same cycle that the previous read's RVALID is asserted (back-to-back throughput one access per cycle).

Reset
REQ-018 SHALL, on RST=1 at a rising edge, set FSM to OWN_NONE, clear all pending-read and error flags; all RVALID/ERR outputs 0 next cycle.
REQ-019 SHALL suppress grants while RST=1 (GNT=0, M_WE=0); a read granted the cycle before reset SHALL NOT produce RVALID.

Configuration
REQ-020 SHALL honour macro DM_ARB_RR_EN: when defined, on simultaneous requests the requester not granted in the most recent contested cycle wins (round robin, CPU first after reset); L_LOCK still overrides; when undefined, fixed priority per REQ-010.

Verification
REQ-021 CPU read only, C_ADR=0x10, M_RDATA=0xDEADBEEF next cycle -> C_GNT=1 same cycle, C_RVALID=1, C_RDATA=0xDEADBEEF one cycle later.
REQ-022 C_REQ and L_REQ both high 3 cycles, macro off -> C_GNT 3 cycles, L_GNT=0, loader served cycle 4; macro on -> grants alternate C,L,C.
REQ-023 Loader write granted, then L_LOCK=1, L_REQ=1 with C_REQ=1 for 4 cycles -> L_GNT 4 cycles, CPU_STALL=1 throughout.
REQ-024 C_REQ, C_WE=1, C_ADR=0x13 -> C_GNT=1, M_WE=0, C_ERR=1 next cycle, no memory write.
REQ-025 Back-to-back CPU reads 0x0,0x4 then RST=1 during second grant -> first RVALID delivered, no RVALID for second, FSM OWN_NONE.
